// File: rtl/bank_write_ctrl.sv
// Keypad-driven write controller for a small colour register bank: select a cell,
// pick a colour, or sweep the whole bank to a fixed colour.
module bank_write_ctrl #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 3,
    parameter int unsigned CLEAR_COLOR = 0,
    parameter int unsigned TIMEOUT     = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key_pos,
    input  logic              key_valid,
    input  logic              clr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_active,
    output logic              busy
);

    localparam int unsigned       TMO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEL   = 2'd1,
        S_WRITE = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              key_q, clr_q, armed_q;
    logic              key_ev, clr_ev;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [ADDR_W-1:0] sel_addr_q, sel_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] colour_q, colour_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              sel_active_q, sel_active_d;
    logic              busy_q, busy_d;

    // armed_q masks the first cycle after reset so a key held through reset is not a press
    assign key_ev = armed_q & key_valid & ~key_q;
    assign clr_ev = armed_q & clr_req & ~clr_q;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= 1'b0;
            clr_q        <= 1'b0;
            armed_q      <= 1'b0;
            tmo_q        <= '0;
            sweep_q      <= '0;
            sel_addr_q   <= '0;
            colour_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            sel_active_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_valid;
            clr_q        <= clr_req;
            armed_q      <= 1'b1;
            tmo_q        <= tmo_d;
            sweep_q      <= sweep_d;
            sel_addr_q   <= sel_addr_d;
            colour_q     <= colour_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            sel_active_q <= sel_active_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; a clear request outranks any key in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clr_ev) begin
                    state_d = S_CLEAR;
                end else if (key_ev) begin
                    state_d = S_SEL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEL: begin
                if (clr_ev) begin
                    state_d = S_CLEAR;
                end else if (key_ev && !key_pos[3]) begin
                    state_d = S_WRITE;
                end else if (key_ev && (key_pos == 4'hF)) begin
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEL;
                end
            end
            S_WRITE: begin
                if (clr_ev) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (sweep_q == SWEEP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, registered so outputs line up with the state they describe
    always_comb begin
        sel_addr_d   = sel_addr_q;
        colour_d     = colour_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        tmo_d        = '0;
        sweep_d      = '0;
        wr_en_d      = 1'b0;
        sel_active_d = (state_d == S_SEL);
        busy_d       = (state_d == S_CLEAR);

        if ((state_q == S_IDLE) && (state_d == S_SEL)) begin
            sel_addr_d = key_pos[ADDR_W-1:0];
        end else begin
            sel_addr_d = sel_addr_q;
        end

        if ((state_q == S_SEL) && (state_d == S_SEL)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end

        case (state_d)
            S_WRITE: begin
                colour_d  = key_pos[DATA_W-1:0];
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr_q;
                wr_data_d = key_pos[DATA_W-1:0];
            end
            S_CLEAR: begin
                // Sweep counter restarts at zero on entry and stops at the last address
                if (state_q == S_CLEAR) begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end else begin
                    sweep_d = '0;
                end
                wr_en_d   = 1'b1;
                wr_addr_d = sweep_d;
                wr_data_d = DATA_W'(CLEAR_COLOR);
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign sel_addr   = sel_addr_q;
    assign sel_active = sel_active_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bank_write_ctrl.sv
// Scoreboard bench for bank_write_ctrl: a transaction-level model predicts every bank
// write and the status outputs; a negedge monitor checks the DUT against it.
module tb_bank_write_ctrl;

    localparam int TB_TIMEOUT = 10;
    localparam int CLR_COLOR  = 0;
    localparam int M_IDLE = 0, M_SEL = 1, M_WR = 2, M_SWEEP = 3;

    logic       clk, rst;
    logic [3:0] key_pos;
    logic       key_valid, clr_req;
    logic [3:0] wr_addr, sel_addr;
    logic [2:0] wr_data;
    logic       wr_en, sel_active, busy;

    bank_write_ctrl #(
        .ADDR_W(4), .DATA_W(3), .CLEAR_COLOR(CLR_COLOR), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .key_pos(key_pos), .key_valid(key_valid), .clr_req(clr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .sel_addr(sel_addr), .sel_active(sel_active), .busy(busy)
    );

    typedef struct {
        int         tag;
        logic [3:0] addr;
        logic [2:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    int         m_mode       = M_IDLE;
    logic       m_prev_k     = 1'b0;
    logic       m_prev_c     = 1'b0;
    logic [3:0] m_sel_addr   = 4'd0;
    int         m_sel_cycles = 0;
    int         m_sweep_last = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_sweep();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{cyc + i, 4'(i), 3'(CLR_COLOR)});
        end
        m_sweep_last = cyc + 15;
        m_mode = M_SWEEP;
    endtask

    // Reference model: cyc is the number of the cycle that begins at this edge
    initial forever begin
        logic kev, cev;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_mode     = M_IDLE;
            m_prev_k   = key_valid;
            m_prev_c   = clr_req;
            m_sel_addr = 4'd0;
            exp_q.delete();
        end else begin
            kev = key_valid && !m_prev_k;
            cev = clr_req && !m_prev_c;
            m_prev_k = key_valid;
            m_prev_c = clr_req;
            case (m_mode)
                M_IDLE: begin
                    if (cev) start_sweep();
                    else if (kev) begin
                        m_mode = M_SEL;
                        m_sel_addr = key_pos;
                        m_sel_cycles = 0;
                    end
                end
                M_SEL: begin
                    if (cev) start_sweep();
                    else if (kev && key_pos < 4'd8) begin
                        exp_q.push_back('{cyc, m_sel_addr, key_pos[2:0]});
                        m_mode = M_WR;
                    end else if (kev && key_pos == 4'd15) m_mode = M_IDLE;
                    else begin
                        m_sel_cycles++;
                        if (m_sel_cycles == TB_TIMEOUT) m_mode = M_IDLE;
                    end
                end
                M_WR: begin
                    if (cev) start_sweep();
                    else m_mode = M_IDLE;
                end
                default: begin
                    if (cyc - 1 == m_sweep_last) m_mode = M_IDLE;
                end
            endcase
        end
    end

    // Monitor: compare writes against the scoreboard and status outputs against the model
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            check("missing_write_addr", {28'd0, 4'hx}, {28'd0, exp_q[0].addr});
            void'(exp_q.pop_front());
        end
        if (wr_en === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                check("wr_addr", 32'(wr_addr), 32'(exp_q[0].addr));
                check("wr_data", 32'(wr_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end
        end
        check("sel_active", 32'(sel_active), 32'(m_mode == M_SEL));
        check("busy", 32'(busy), 32'(m_mode == M_SWEEP));
        check("sel_addr", 32'(sel_addr), 32'(m_sel_addr));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        key_pos = k;
        key_valid = 1'b1;
        tick(hold);
        key_valid = 1'b0;
        tick(1);
    endtask

    task automatic clr_pulse(input int hold);
        clr_req = 1'b1;
        tick(hold);
        clr_req = 1'b0;
        tick(1);
    endtask

    initial begin
        int found;
        int r;
        rst = 1'b1;
        key_pos = 4'd0;
        key_valid = 1'b0;
        clr_req = 1'b0;
        tick(3);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_sel_addr", 32'(sel_addr), 32'd0);
        rst = 1'b0;
        tick(2);

        // Select cell 5, colour 3
        press(4'd5, 2);
        press(4'd3, 3);
        tick(2);
        check("sel_addr_after_write", 32'(sel_addr), 32'd5);

        // Select 9 then cancel; select 9, ignored key 12, cancel
        press(4'd9, 1);
        press(4'd15, 1);
        press(4'd9, 1);
        press(4'd12, 2);
        press(4'd15, 1);
        tick(2);

        // Timeout with no further keys, then timeout not restarted by ignored keys
        press(4'd2, 1);
        tick(TB_TIMEOUT + 3);
        check("timeout_sel_active", 32'(sel_active), 32'd0);
        press(4'd4, 1);
        tick(4);
        press(4'd10, 1);
        tick(TB_TIMEOUT);

        // Clear from IDLE with key presses during the sweep
        clr_pulse(3);
        press(4'd6, 1);
        press(4'd1, 1);
        tick(16);

        // Key and clear in the same IDLE cycle
        key_pos = 4'd3; key_valid = 1'b1; clr_req = 1'b1;
        tick(1);
        key_valid = 1'b0; clr_req = 1'b0;
        tick(20);

        // Colour key exactly as clear rises in SEL
        press(4'd7, 1);
        key_pos = 4'd2; key_valid = 1'b1; clr_req = 1'b1;
        tick(1);
        key_valid = 1'b0; clr_req = 1'b0;
        tick(20);

        // Clear rising during the WRITE cycle is deferred behind the write
        press(4'd11, 1);
        key_pos = 4'd6; key_valid = 1'b1;
        tick(1);
        clr_req = 1'b1;
        tick(1);
        key_valid = 1'b0; clr_req = 1'b0;
        tick(20);

        // Reset at sweep address 7 with a key held across reset release
        clr_req = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(1);
            if (wr_en === 1'b1 && wr_addr == 4'd7) found = 1;
        end
        check("sweep_reached_addr7", 32'(found), 32'd1);
        clr_req = 1'b0;
        rst = 1'b1;
        key_pos = 4'd9;
        key_valid = 1'b1;
        tick(1);
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("held_key_no_sel", 32'(sel_active), 32'd0);
        key_valid = 1'b0;
        tick(2);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) clr_pulse($urandom_range(1, 3));
            else if (r == 1) tick($urandom_range(0, 12));
            else if (r == 2) begin
                key_pos = 4'($urandom_range(0, 15));
                key_valid = 1'b1; clr_req = 1'b1;
                tick(1);
                key_valid = 1'b0; clr_req = 1'b0;
                tick(1);
            end else press(4'($urandom_range(0, 15)), $urandom_range(1, 3));
        end
        tick(40);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bank_write_ctrl.md
BANK_WRITE_CTRL -- requirements
Module: bank_write_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the register-bank address width (16 cells).
REQ-002 SHALL have parameter DATA_W, default 3, meaning the colour word width (R,G,B bits).
REQ-003 SHALL have parameter CLEAR_COLOR, default 0, meaning the colour written to every cell during a clear sweep.
REQ-004 SHALL have parameter TIMEOUT, default 50_000_000, meaning the idle cycles allowed in SEL before the selection is abandoned.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 key_pos  input  4  keypad key code, valid while key_valid=1.
REQ-008 key_valid  input  1  keypad "key pressed" level; high for one or more cycles per press.
REQ-009 clr_req  input  1  request to clear the whole bank; level, acted on at its rising edge.
REQ-010 wr_addr  output  ADDR_W  bank write address.
REQ-011 wr_data  output  DATA_W  bank write data.
REQ-012 wr_en  output  1  bank write strobe; one write per cycle high.
REQ-013 sel_addr  output  ADDR_W  currently selected cell, for the seven-segment display.
REQ-014 sel_active  output  1  high while a cell is selected and a colour is awaited.
REQ-015 busy  output  1  high during a clear sweep.

Function
REQ-016 SHALL register key_valid and clr_req once and treat only a 0->1 transition (current=1, previous=0) as an event; held levels produce no further events.
REQ-017 SHALL implement states IDLE, SEL, WRITE, CLEAR, all registered.
REQ-018 IDLE: key event -> latch key_pos[ADDR_W-1:0] into sel_addr, go to SEL, clear timeout counter.
REQ-019 SEL: key event with key_pos<8 -> latch colour key_pos[DATA_W-1:0], go to WRITE.
REQ-020 SEL: key event with key_pos=15 -> cancel, go to IDLE, no write.
REQ-021 SEL: key events with key_pos 8..14 SHALL be ignored and SHALL NOT restart the timeout.
REQ-022 SEL: timeout counter increments each cycle without a valid colour or cancel key; on reaching TIMEOUT-1 go to IDLE with no write.
REQ-023 WRITE: exactly one cycle with wr_en=1, wr_addr=sel_addr, wr_data=latched colour, then IDLE.
REQ-024 Latency: colour-key event in cycle n -> wr_en=1 in cycle n+1 only.
REQ-025 clr_req event in IDLE or SEL -> go to CLEAR, discarding any selection; takes priority over a key event in the same cycle.
REQ-026 clr_req event in WRITE SHALL be deferred: the pending write completes, then CLEAR is entered on the next cycle.
REQ-027 CLEAR: wr_en=1 for exactly 2^ADDR_W consecutive cycles, wr_addr=0,1,...,2^ADDR_W-1, wr_data=CLEAR_COLOR, busy=1; after the last address go to IDLE; the address counter SHALL NOT wrap beyond the sweep.
REQ-028 CLEAR: key and clr_req events SHALL be ignored and not queued.
REQ-029 sel_active=1 only in SEL; busy=1 only in CLEAR; wr_en=0 in IDLE and SEL.
REQ-030 sel_addr SHALL hold the last selected cell after leaving SEL until the next selection.
REQ-031 wr_addr and wr_data SHALL hold their last values while wr_en=0.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE and zero all outputs, the timeout counter, the sweep counter, the latched colour and the edge-detect registers.
REQ-033 Reset mid-SEL or mid-CLEAR SHALL abort with no further wr_en pulses; a key_valid held high across reset release SHALL NOT count as an event.

Verification
REQ-034 Press key 5, release, press key 3 -> single wr_en pulse one cycle after the second press, wr_addr=5, wr_data=3; sel_addr=5.
REQ-035 Press key 9, then key 15 -> no wr_en, return to IDLE; pressing key 12 in SEL causes no write.
REQ-036 TIMEOUT=10 override: press key 2, no further keys -> sel_active falls after 10 cycles, no write.
REQ-037 clr_req rising in IDLE -> 16 consecutive wr_en cycles, addresses 0..15, data 0, busy=1 throughout; key presses during sweep cause no writes.
REQ-038 key event and clr_req event in the same IDLE cycle -> clear sweep only; colour key issued exactly as clr_req rises in SEL -> no cell write, sweep starts.
REQ-039 rst asserted at sweep address 7 -> wr_en low from next cycle, all outputs 0, IDLE.
